// File: rtl/gs_ddram.sv
// gs_ddram: General Sound byte port onto the 64-bit DDR3 Avalon bus,
// with a single-line read cache and write-through stores.
module gs_ddram (
    input  logic        DDRAM_CLK,
    input  logic        reset,
    input  logic [20:0] addr,
    input  logic [7:0]  din,
    input  logic        we,
    input  logic        rd,
    output logic [7:0]  dout,
    output logic        ready,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE
);
    localparam logic [3:0] BASE = 4'b0011;

    typedef enum logic [1:0] {
        IDLE,
        RD_CMD,
        RD_WAIT,
        WR_CMD
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        old_rd;
    logic        old_we;
    logic [20:0] a;
    logic [63:0] line;
    logic [17:0] tag;
    logic        valid;
    logic        rd_edge;
    logic        we_edge;
    logic        hit;
    logic        acc_wr;
    logic        acc_hit;
    logic        acc_miss;
    logic        rd_taken;
    logic        rd_done;
    logic        wr_done;

    assign rd_edge = rd & ~old_rd;
    assign we_edge = we & ~old_we;
    assign hit     = valid && (tag == addr[20:3]);

    assign ready          = (state == IDLE);
    assign dout           = line[{a[2:0], 3'b000} +: 8];
    assign DDRAM_ADDR     = {BASE, 7'b0, a[20:3]};
    assign DDRAM_BURSTCNT = 8'd1;

    always_ff @(posedge DDRAM_CLK) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (we_edge)      state_nx = WR_CMD;
                else if (rd_edge) state_nx = hit ? IDLE : RD_CMD;
            end
            RD_CMD:  if (!DDRAM_BUSY)      state_nx = RD_WAIT;
            RD_WAIT: if (DDRAM_DOUT_READY) state_nx = IDLE;
            WR_CMD:  if (!DDRAM_BUSY)      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Write wins over a read that rises in the same cycle.
    always_comb begin
        acc_wr   = 1'b0;
        acc_hit  = 1'b0;
        acc_miss = 1'b0;
        rd_taken = 1'b0;
        rd_done  = 1'b0;
        wr_done  = 1'b0;
        unique case (state)
            IDLE: begin
                acc_wr   = we_edge;
                acc_hit  = ~we_edge & rd_edge & hit;
                acc_miss = ~we_edge & rd_edge & ~hit;
            end
            RD_CMD:  rd_taken = ~DDRAM_BUSY;
            RD_WAIT: rd_done  = DDRAM_DOUT_READY;
            WR_CMD:  wr_done  = ~DDRAM_BUSY;
            default: ;
        endcase
    end

    always_ff @(posedge DDRAM_CLK) begin
        if (reset) begin
            old_rd    <= 1'b0;
            old_we    <= 1'b0;
            a         <= '0;
            line      <= '0;
            tag       <= '0;
            valid     <= 1'b0;
            DDRAM_RD  <= 1'b0;
            DDRAM_WE  <= 1'b0;
            DDRAM_DIN <= '0;
            DDRAM_BE  <= '0;
        end else begin
            old_rd <= rd;
            old_we <= we;
            if (acc_wr) begin
                a         <= addr;
                DDRAM_WE  <= 1'b1;
                DDRAM_DIN <= {8{din}};
                DDRAM_BE  <= 8'(8'd1 << addr[2:0]);
                if (hit) line[{addr[2:0], 3'b000} +: 8] <= din;
            end
            if (acc_hit) a <= addr;
            if (acc_miss) begin
                a        <= addr;
                tag      <= addr[20:3];
                DDRAM_RD <= 1'b1;
            end
            if (rd_taken) DDRAM_RD <= 1'b0;
            if (rd_done) begin
                line  <= DDRAM_DOUT;
                valid <= 1'b1;
            end
            if (wr_done) DDRAM_WE <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gs_ddram.sv
// tb_gs_ddram: random GS byte traffic against a byte-level memory model
// and an Avalon DDR responder with random waitrequest and read latency.
module tb_gs_ddram;
    logic        clk = 1'b0;
    logic        reset;
    logic [20:0] addr;
    logic [7:0]  din;
    logic        we;
    logic        rd;
    logic [7:0]  dout;
    logic        ready;
    logic        DDRAM_BUSY = 1'b0;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT = '0;
    logic        DDRAM_DOUT_READY = 1'b0;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    int n_chk = 0;
    int n_err = 0;

    gs_ddram dut (
        .DDRAM_CLK(clk),
        .reset(reset),
        .addr(addr),
        .din(din),
        .we(we),
        .rd(rd),
        .dout(dout),
        .ready(ready),
        .DDRAM_BUSY(DDRAM_BUSY),
        .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
        .DDRAM_ADDR(DDRAM_ADDR),
        .DDRAM_DOUT(DDRAM_DOUT),
        .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
        .DDRAM_RD(DDRAM_RD),
        .DDRAM_DIN(DDRAM_DIN),
        .DDRAM_BE(DDRAM_BE),
        .DDRAM_WE(DDRAM_WE)
    );

    always #5 clk = ~clk;

    logic [63:0] ddr [logic [28:0]];
    logic [7:0]  ref_b [logic [20:0]];
    bit          mvalid = 0;
    logic [17:0] mtag = '0;

    int          cyc = 0;
    int          stall_until = 0;
    int          lat_force = 0;
    int          resp_cnt = 0;
    logic [63:0] resp_data;
    int          rd_count = 0;
    int          wr_count = 0;
    int          resp_count = 0;
    int          stall_err = 0;
    logic [28:0] last_rd_addr = '0;
    logic [28:0] last_wr_addr = '0;
    logic [7:0]  last_wr_be = '0;
    logic [63:0] last_wr_din = '0;
    bit          prev_rd_st = 0;
    bit          prev_wr_st = 0;
    logic [28:0] prev_addr;
    logic [63:0] prev_din;
    logic [7:0]  prev_be;

    function automatic logic [63:0] init_word(input logic [28:0] w);
        return ({35'd0, w} * 64'h9E3779B97F4A7C15) ^ 64'h0F1E2D3C4B5A6978;
    endfunction

    function automatic logic [63:0] ddr_word(input logic [28:0] w);
        if (ddr.exists(w)) return ddr[w];
        return init_word(w);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [20:0] a);
        logic [63:0] wd;
        if (ref_b.exists(a)) return ref_b[a];
        wd = init_word({4'b0011, 7'b0, a[20:3]});
        return wd[{a[2:0], 3'b000} +: 8];
    endfunction

    // Avalon slave model, acting on the falling edge.
    always @(negedge clk) begin
        logic [63:0] wd;
        cyc++;
        DDRAM_DOUT_READY = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                DDRAM_DOUT = resp_data;
                DDRAM_DOUT_READY = 1'b1;
                resp_count++;
            end
        end
        DDRAM_BUSY = (cyc < stall_until) ? 1'b1 : ($urandom_range(3) == 0);
        if (reset) begin
            prev_rd_st = 0;
            prev_wr_st = 0;
        end
        if (prev_rd_st && !(DDRAM_RD && DDRAM_ADDR == prev_addr))
            stall_err++;
        if (prev_wr_st && !(DDRAM_WE && DDRAM_ADDR == prev_addr &&
                            DDRAM_DIN == prev_din && DDRAM_BE == prev_be))
            stall_err++;
        prev_rd_st = DDRAM_RD && DDRAM_BUSY;
        prev_wr_st = DDRAM_WE && DDRAM_BUSY;
        prev_addr  = DDRAM_ADDR;
        prev_din   = DDRAM_DIN;
        prev_be    = DDRAM_BE;
        if (DDRAM_RD && !DDRAM_BUSY) begin
            rd_count++;
            last_rd_addr = DDRAM_ADDR;
            resp_data = ddr_word(DDRAM_ADDR);
            resp_cnt = (lat_force > 0) ? lat_force : int'($urandom_range(4, 1));
        end
        if (DDRAM_WE && !DDRAM_BUSY) begin
            wr_count++;
            last_wr_addr = DDRAM_ADDR;
            last_wr_be   = DDRAM_BE;
            last_wr_din  = DDRAM_DIN;
            wd = ddr_word(DDRAM_ADDR);
            for (int i = 0; i < 8; i++)
                if (DDRAM_BE[i]) wd[8*i +: 8] = DDRAM_DIN[8*i +: 8];
            ddr[DDRAM_ADDR] = wd;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic rd_chk(input logic [20:0] a);
        logic [7:0] exp;
        bit         exp_hit;
        bit         fell;
        int         r0, p0, n;
        exp     = ref_byte(a);
        exp_hit = mvalid && (mtag == a[20:3]);
        r0 = rd_count;
        p0 = resp_count;
        addr = a;
        rd = 1'b1;
        step();
        fell = !ready;
        n = 0;
        while (!ready && n < 300) begin
            step();
            n++;
        end
        check("rd_tmo", ready, 1);
        check("rd_data", dout, exp);
        check("rd_fell", fell, !exp_hit);
        check("rd_ddr", rd_count - r0, exp_hit ? 0 : 1);
        if (!exp_hit) begin
            check("rd_addr", last_rd_addr, {4'b0011, 7'b0, a[20:3]});
            check("rd_resp", resp_count - p0, 1);
        end
        rd = 1'b0;
        mvalid = 1;
        mtag = a[20:3];
        step();
    endtask

    task automatic wr_chk(input logic [20:0] a, input logic [7:0] d);
        bit         fell;
        int         w0, n;
        logic [7:0] be;
        w0 = wr_count;
        addr = a;
        din = d;
        we = 1'b1;
        step();
        fell = !ready;
        n = 0;
        while (!ready && n < 300) begin
            step();
            n++;
        end
        be = 8'h01 << a[2:0];
        check("wr_tmo", ready, 1);
        check("wr_fell", fell, 1);
        check("wr_ddr", wr_count - w0, 1);
        check("wr_addr", last_wr_addr, {4'b0011, 7'b0, a[20:3]});
        check("wr_be", last_wr_be, be);
        check("wr_din", last_wr_din, {8{d}});
        we = 1'b0;
        ref_b[a] = d;
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pre;
        logic [17:0] lines [4];
        logic [20:0] ra;
        int          r0, w0, n;

        pre = 64'h8877665544332211;
        ddr[29'h0600_0000] = pre;
        for (int i = 0; i < 8; i++) ref_b[21'(i)] = pre[8*i +: 8];

        reset = 1'b1;
        addr = '0;
        din = '0;
        we = 1'b0;
        rd = 1'b0;
        repeat (3) step();
        check("rst_ready", ready, 1);
        check("rst_rd", DDRAM_RD, 0);
        check("rst_we", DDRAM_WE, 0);
        check("rst_dout", dout, 0);
        check("rst_be", DDRAM_BE, 0);
        check("rst_din", DDRAM_DIN, 0);
        check("burstcnt", DDRAM_BURSTCNT, 1);
        reset = 1'b0;
        step();

        rd_chk(21'h000000);
        rd_chk(21'h000005);
        rd_chk(21'h1FFFF8);
        wr_chk(21'h1FFFFB, 8'hA5);
        rd_chk(21'h1FFFFB);
        rd_chk(21'h1FFFF8);

        stall_until = cyc + 6;
        rd_chk(21'h0C3210);
        check("rd_stall_stable", stall_err, 0);
        stall_until = cyc + 4;
        wr_chk(21'h0C3213, 8'h3C);
        check("wr_stall_stable", stall_err, 0);
        rd_chk(21'h0C3213);

        // rd and we rising together: only the write goes out
        r0 = rd_count;
        w0 = wr_count;
        addr = 21'h0ABCD2;
        din = 8'h5A;
        rd = 1'b1;
        we = 1'b1;
        step();
        n = 0;
        while (!ready && n < 300) begin
            step();
            n++;
        end
        check("both_tmo", ready, 1);
        check("both_wr", wr_count - w0, 1);
        check("both_rd", rd_count - r0, 0);
        ref_b[21'h0ABCD2] = 8'h5A;
        rd = 1'b0;
        we = 1'b0;
        step();

        // a read edge during a write is dropped
        r0 = rd_count;
        w0 = wr_count;
        stall_until = cyc + 3;
        addr = 21'h0ABCD3;
        din = 8'hC3;
        we = 1'b1;
        step();
        check("busy_ready", ready, 0);
        addr = 21'h155550;
        rd = 1'b1;
        n = 0;
        while (!ready && n < 300) begin
            step();
            n++;
        end
        repeat (3) step();
        check("ign_ready", ready, 1);
        check("ign_rd", rd_count - r0, 0);
        check("ign_wr", wr_count - w0, 1);
        ref_b[21'h0ABCD3] = 8'hC3;
        rd = 1'b0;
        we = 1'b0;
        step();
        rd_chk(21'h0ABCD3);
        rd_chk(21'h0ABCD2);

        // reset while the read response is outstanding
        r0 = rd_count;
        lat_force = 20;
        addr = 21'h000200;
        rd = 1'b1;
        n = 0;
        while (rd_count == r0 && n < 300) begin
            step();
            n++;
        end
        check("abort_issued", rd_count - r0, 1);
        lat_force = 0;
        rd = 1'b0;
        reset = 1'b1;
        step();
        check("abort_ready", ready, 1);
        check("abort_rd", DDRAM_RD, 0);
        reset = 1'b0;
        mvalid = 0;
        repeat (25) step();
        check("late_ready", ready, 1);
        rd_chk(21'h000200);

        for (int i = 0; i < 4; i++) lines[i] = 18'($urandom);
        for (int k = 0; k < 120; k++) begin
            ra = {lines[$urandom_range(3)], 3'($urandom_range(7))};
            if ($urandom_range(9) < 3) wr_chk(ra, 8'($urandom));
            else                       rd_chk(ra);
        end
        check("stall_stable", stall_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
